// File: rtl/uart_rx_fifo_param.sv
// UART receiver with a 2-flop synchroniser, 3-sample majority vote, parity/stop checking and a
// first-word fall-through output FIFO (ready/valid) that raises rq every GROUP_N pushed frames.
module uart_rx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int GROUP_N    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             rx,
    output logic [DATA_BITS-1:0]             m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill,
    output logic                             rq,
    output logic                             frame_err,
    output logic                             parity_err,
    output logic                             overflow,
    output logic                             busy
);
    localparam int MID = OVERSAMPLE / 2;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = $clog2(FIFO_DEPTH + 1);
    localparam int GW  = (GROUP_N > 1) ? $clog2(GROUP_N) : 1;

    localparam logic [SCW-1:0] SC_V0   = SCW'(MID - 1);
    localparam logic [SCW-1:0] SC_V1   = SCW'(MID);
    localparam logic [SCW-1:0] SC_V2   = SCW'(MID + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 state;
    logic                   rx_meta, rxs;
    logic [SCW-1:0]         sc;
    logic [BIW-1:0]         bit_idx;
    logic                   stop_idx;
    logic                   v0, v1, bitv, par_ok;
    logic [DATA_BITS-1:0]   shreg;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [FW-1:0]          count;
    logic [GW-1:0]          grp;

    logic vote, commit, good, full, pop, push;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Third vote sample is the live rxs at sc=MID+1, so decisions are taken on that tick.
    assign vote   = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign commit = en && (state == S_STOP) && (sc == SC_V2) &&
                    (!vote || (stop_idx == 1'(STOP_BITS - 1)));
    assign good   = commit && vote && par_ok;
    assign pop    = m_valid && m_ready;
    assign full   = (count == FW'(FIFO_DEPTH));
    assign push   = good && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sc       <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            v0       <= 1'b1;
            v1       <= 1'b1;
            bitv     <= 1'b0;
            par_ok   <= 1'b1;
            shreg    <= '0;
        end else if (en) begin
            sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
            if (sc == SC_V0) v0 <= rxs;
            if (sc == SC_V1) v1 <= rxs;
            case (state)
                S_IDLE: begin
                    sc <= '0;
                    if (!rxs) begin
                        state  <= S_START;
                        par_ok <= 1'b1;
                    end
                end
                S_START: begin
                    if (sc == SC_V2 && vote) begin
                        state <= S_IDLE;
                    end else if (sc == SC_LAST) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (sc == SC_V2) bitv <= vote;
                    if (sc == SC_LAST) begin
                        shreg   <= {bitv, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIW'(1);
                        if (bit_idx == BIW'(DATA_BITS - 1)) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (sc == SC_V2) par_ok <= (((^shreg) ^ vote) == (PARITY == 2));
                    if (sc == SC_LAST) state <= S_STOP;
                end
                S_STOP: begin
                    if (sc == SC_V2) begin
                        if (!vote) state <= S_BREAK;
                        else if (stop_idx == 1'(STOP_BITS - 1)) state <= S_IDLE;
                    end else if (sc == SC_LAST) begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            grp        <= '0;
            rq         <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= commit && !vote;
            parity_err <= commit && vote && !par_ok;
            overflow   <= good && full && !pop;
            rq         <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (grp == GW'(GROUP_N - 1)) begin
                    grp <= '0;
                    rq  <= 1'b1;
                end else begin
                    grp <= grp + GW'(1);
                end
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + FW'(push) - FW'(pop);
        end
    end

    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign fill    = count;
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench: an 8N1 instance and an 8E1 instance driven by per-scenario tasks.
module tb_uart_rx_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, rx, m_ready, rx_p, m_ready_p;
    logic [7:0] m_data, m_data_p;
    logic [2:0] fill, fill_p;
    logic m_valid, rq, frame_err, parity_err, overflow, busy;
    logic m_valid_p, rq_p, frame_err_p, parity_err_p, overflow_p, busy_p;

    int compares = 0;
    int fails = 0;
    int rq_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovf_cnt = 0;
    int rq_p_cnt = 0, ferr_p_cnt = 0, perr_p_cnt = 0, ovf_p_cnt = 0;
    logic [7:0] pop_q[$];
    bit slow_en = 1'b0;

    uart_rx_fifo_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1),
                         .FIFO_DEPTH(4), .GROUP_N(4)) u_dut (
        .clk(clk), .reset(reset), .en(en), .rx(rx),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fill(fill),
        .rq(rq), .frame_err(frame_err), .parity_err(parity_err),
        .overflow(overflow), .busy(busy));

    uart_rx_fifo_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1),
                         .FIFO_DEPTH(4), .GROUP_N(4)) u_dut_p (
        .clk(clk), .reset(reset), .en(en), .rx(rx_p),
        .m_data(m_data_p), .m_valid(m_valid_p), .m_ready(m_ready_p), .fill(fill_p),
        .rq(rq_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overflow(overflow_p), .busy(busy_p));

    // Pulse counters and pop log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (rq) rq_cnt++;
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (overflow) ovf_cnt++;
            if (rq_p) rq_p_cnt++;
            if (frame_err_p) ferr_p_cnt++;
            if (parity_err_p) perr_p_cnt++;
            if (overflow_p) ovf_p_cnt++;
            if (m_valid && m_ready) pop_q.push_back(m_data);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        if (slow_en) begin
            en = 1'b0;
            @(posedge clk); #1;
            en = 1'b1;
        end
    endtask

    task automatic send_bit(input bit use_p, input logic b);
        if (use_p) rx_p = b; else rx = b;
        repeat (16) tick();
    endtask

    task automatic send_frame(input bit use_p, input logic [7:0] d, input logic pbit,
                              input logic stop_v);
        send_bit(use_p, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(use_p, d[i]);
        if (use_p) send_bit(use_p, pbit);
        send_bit(use_p, stop_v);
        if (use_p) rx_p = 1'b1; else rx = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; rx = 1'b1; rx_p = 1'b1;
        m_ready = 1'b0; m_ready_p = 1'b0; slow_en = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (fill !== 3'd1) begin $display("FAIL reset_prefill: got %0d want 1", fill); fails++; end
        reset = 1'b1;
        idle(2);
        compares++;
        if (fill !== 3'd0) begin $display("FAIL reset_fill: got %0d want 0", fill); fails++; end
        compares++;
        if (m_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", m_valid); fails++; end
        compares++;
        if (m_data !== 8'h00) begin $display("FAIL reset_data: got %0h want 0", m_data); fails++; end
        compares++;
        if ({rq, frame_err, parity_err, overflow, busy} !== 5'b0) begin
            $display("FAIL reset_flags: got %05b want 00000", {rq, frame_err, parity_err, overflow, busy});
            fails++;
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int f0, p0, o0;
        do_reset();
        f0 = ferr_cnt; p0 = perr_cnt; o0 = ovf_cnt;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (m_valid !== 1'b1) begin $display("FAIL basic_valid: got %0b want 1", m_valid); fails++; end
        compares++;
        if (m_data !== 8'hA5) begin $display("FAIL basic_data: got %0h want a5", m_data); fails++; end
        compares++;
        if (fill !== 3'd1) begin $display("FAIL basic_fill: got %0d want 1", fill); fails++; end
        compares++;
        if ((ferr_cnt - f0) + (perr_cnt - p0) + (ovf_cnt - o0) != 0) begin
            $display("FAIL basic_errs: got %0d pulses want 0", (ferr_cnt - f0) + (perr_cnt - p0) + (ovf_cnt - o0));
            fails++;
        end
        compares++;
        if (busy !== 1'b0) begin $display("FAIL basic_busy: got %0b want 0", busy); fails++; end
    endtask

    task automatic test_glitch();
        int f0;
        do_reset();
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(5);
        compares++;
        if (busy !== 1'b1) begin $display("FAIL glitch_busy_hi: got %0b want 1", busy); fails++; end
        rx = 1'b1;
        idle(40);
        compares++;
        if (busy !== 1'b0) begin $display("FAIL glitch_busy_lo: got %0b want 0", busy); fails++; end
        idle(200);
        compares++;
        if (fill !== 3'd0) begin $display("FAIL glitch_fill: got %0d want 0", fill); fails++; end
        compares++;
        if (ferr_cnt != f0) begin $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); fails++; end
    endtask

    task automatic test_parity();
        int p0, f0, r0, o0;
        do_reset();
        p0 = perr_p_cnt; f0 = ferr_p_cnt; r0 = rq_p_cnt; o0 = ovf_p_cnt;
        send_frame(1'b1, 8'h07, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (perr_p_cnt - p0 != 1) begin $display("FAIL parity_bad_pulse: got %0d want 1", perr_p_cnt - p0); fails++; end
        compares++;
        if (fill_p !== 3'd0) begin $display("FAIL parity_bad_fill: got %0d want 0", fill_p); fails++; end
        send_frame(1'b1, 8'h07, 1'b1, 1'b1);
        idle(20);
        compares++;
        if (fill_p !== 3'd1) begin $display("FAIL parity_good_fill: got %0d want 1", fill_p); fails++; end
        compares++;
        if (m_valid_p !== 1'b1 || m_data_p !== 8'h07) begin
            $display("FAIL parity_good_data: got v=%0b d=%0h want v=1 d=07", m_valid_p, m_data_p); fails++;
        end
        send_frame(1'b1, 8'h03, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (fill_p !== 3'd2) begin $display("FAIL parity_even_fill: got %0d want 2", fill_p); fails++; end
        compares++;
        if (perr_p_cnt - p0 != 1) begin $display("FAIL parity_total: got %0d want 1", perr_p_cnt - p0); fails++; end
        compares++;
        if ((ferr_p_cnt - f0) + (rq_p_cnt - r0) + (ovf_p_cnt - o0) != 0 || busy_p !== 1'b0) begin
            $display("FAIL parity_other: got %0d pulses busy=%0b want 0 0",
                     (ferr_p_cnt - f0) + (rq_p_cnt - r0) + (ovf_p_cnt - o0), busy_p);
            fails++;
        end
    endtask

    task automatic test_overflow();
        int o0, r0, q0;
        do_reset();
        o0 = ovf_cnt; r0 = rq_cnt; q0 = pop_q.size();
        for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1);
        idle(20);
        compares++;
        if (fill !== 3'd4) begin $display("FAIL ovf_fill4: got %0d want 4", fill); fails++; end
        compares++;
        if (ovf_cnt != o0) begin $display("FAIL ovf_early: got %0d want 0", ovf_cnt - o0); fails++; end
        compares++;
        if (rq_cnt - r0 != 1) begin $display("FAIL ovf_rq: got %0d want 1", rq_cnt - r0); fails++; end
        send_frame(1'b0, 8'h05, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (ovf_cnt - o0 != 1) begin $display("FAIL ovf_pulse: got %0d want 1", ovf_cnt - o0); fails++; end
        compares++;
        if (fill !== 3'd4 || m_data !== 8'h01) begin
            $display("FAIL ovf_hold: got fill=%0d d=%0h want 4 01", fill, m_data); fails++;
        end
        m_ready = 1'b1;
        idle(4);
        m_ready = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            compares++;
            if (q0 + i >= pop_q.size() || pop_q[q0 + i] !== 8'(i + 1)) begin
                $display("FAIL ovf_pop%0d: got %0h want %0h", i,
                         (q0 + i < pop_q.size()) ? pop_q[q0 + i] : 8'hxx, 8'(i + 1));
                fails++;
            end
        end
        compares++;
        if (fill !== 3'd0 || m_valid !== 1'b0) begin
            $display("FAIL ovf_empty: got fill=%0d v=%0b want 0 0", fill, m_valid); fails++;
        end
    endtask

    task automatic test_group();
        int r0, f0, q0;
        do_reset();
        r0 = rq_cnt; f0 = ferr_cnt; q0 = pop_q.size();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_frame(1'b0, 8'h10 + 8'(i), 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0);
        idle(30);
        compares++;
        if (rq_cnt - r0 != 2) begin $display("FAIL group_rq: got %0d want 2", rq_cnt - r0); fails++; end
        compares++;
        if (ferr_cnt - f0 != 1) begin $display("FAIL group_ferr: got %0d want 1", ferr_cnt - f0); fails++; end
        compares++;
        if (pop_q.size() - q0 != 8) begin $display("FAIL group_npop: got %0d want 8", pop_q.size() - q0); fails++; end
        for (int i = 0; i < 8; i++) begin
            compares++;
            if (q0 + i >= pop_q.size() || pop_q[q0 + i] !== 8'h10 + 8'(i)) begin
                $display("FAIL group_pop%0d: got %0h want %0h", i,
                         (q0 + i < pop_q.size()) ? pop_q[q0 + i] : 8'hxx, 8'h10 + 8'(i));
                fails++;
            end
        end
        compares++;
        if (busy !== 1'b0) begin $display("FAIL group_busy: got %0b want 0", busy); fails++; end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int f0, q0;
        do_reset();
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        compares++;
        if (busy !== 1'b1) begin $display("FAIL rmid_busy: got %0b want 1", busy); fails++; end
        reset = 1'b1; rx = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(20);
        compares++;
        if (fill !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL rmid_abort: got fill=%0d busy=%0b want 0 0", fill, busy); fails++;
        end
        f0 = ferr_cnt; q0 = pop_q.size();
        send_frame(1'b0, 8'h55, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (fill !== 3'd1 || m_data !== 8'h55) begin
            $display("FAIL rmid_frame: got fill=%0d d=%0h want 1 55", fill, m_data); fails++;
        end
        rx = 1'b0;
        idle(480);
        compares++;
        if (ferr_cnt - f0 != 1) begin $display("FAIL break_ferr: got %0d want 1", ferr_cnt - f0); fails++; end
        compares++;
        if (fill !== 3'd1 || busy !== 1'b1) begin
            $display("FAIL break_hold: got fill=%0d busy=%0b want 1 1", fill, busy); fails++;
        end
        rx = 1'b1;
        idle(20);
        compares++;
        if (busy !== 1'b0) begin $display("FAIL break_exit: got %0b want 0", busy); fails++; end
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        idle(20);
        compares++;
        if (fill !== 3'd2) begin $display("FAIL break_next_fill: got %0d want 2", fill); fails++; end
        m_ready = 1'b1;
        idle(2);
        m_ready = 1'b0;
        idle(2);
        compares++;
        if (pop_q.size() != q0 + 2 || pop_q[q0] !== 8'h55 || pop_q[q0 + 1] !== 8'hC3) begin
            $display("FAIL break_pops: got n=%0d want 55,c3", pop_q.size() - q0); fails++;
        end
    endtask

    task automatic test_en_gating();
        int q0;
        do_reset();
        q0 = pop_q.size();
        slow_en = 1'b1;
        send_frame(1'b0, 8'h3A, 1'b0, 1'b1);
        send_frame(1'b0, 8'hC6, 1'b0, 1'b1);
        slow_en = 1'b0;
        idle(20);
        compares++;
        if (fill !== 3'd2) begin $display("FAIL en_fill: got %0d want 2", fill); fails++; end
        m_ready = 1'b1;
        idle(2);
        m_ready = 1'b0;
        idle(2);
        compares++;
        if (pop_q.size() != q0 + 2 || pop_q[q0] !== 8'h3A || pop_q[q0 + 1] !== 8'hC6) begin
            $display("FAIL en_pops: got n=%0d want 3a,c6", pop_q.size() - q0); fails++;
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; rx = 1'b1; rx_p = 1'b1;
        m_ready = 1'b0; m_ready_p = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_overflow();
        test_group();
        test_reset_mid();
        test_en_gating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
